// File: rtl/alu_seq_mul.sv
// Shift-and-add MUL sequencer: unsigned product truncated to BITSIZE, every add done by an external ALU.
// Latency: done pulses k+1 cycles after an accepted start (k = MSB index of op_b plus 1), or 1 cycle if op_b==0.
// Backpressure: none; start is taken only in IDLE, and a start seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start, op_a, op_b   - request and operands (captured on an accepted start)
//   busy, done          - busy in RUN/DONE, done is a one-cycle pulse in DONE
//   product, zero       - registered result and its zero flag, held until the next accepted start
//   alu_a/alu_b/alu_op  - drive to the external combinational ALU (4'h4 add, 4'h6 zero)
//   alu_result, alu_z   - same-cycle ALU response
module alu_seq_mul #(
    parameter int BITSIZE = 64,
    parameter int CNTW    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BITSIZE-1:0] op_a,
    input  logic [BITSIZE-1:0] op_b,
    output logic               busy,
    output logic               done,
    output logic [BITSIZE-1:0] product,
    output logic               zero,
    output logic [BITSIZE-1:0] alu_a,
    output logic [BITSIZE-1:0] alu_b,
    output logic [3:0]         alu_op,
    input  logic [BITSIZE-1:0] alu_result,
    input  logic               alu_z
);

    localparam logic [3:0]      OP_ADD   = 4'h4;
    localparam logic [3:0]      OP_ZERO  = 4'h6;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BITSIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [BITSIZE-1:0] acc_q;
    logic [BITSIZE-1:0] mcand_q;
    logic [BITSIZE-1:0] mplier_q;
    logic [CNTW-1:0]    count_q;
    logic               busy_q;
    logic               done_q;
    logic [BITSIZE-1:0] product_q;
    logic               zero_q;

    logic [BITSIZE-1:0] mcand_d;
    logic [BITSIZE-1:0] mplier_d;
    logic [CNTW-1:0]    count_d;
    logic               run_last;

    assign mcand_d  = mcand_q << 1;
    assign mplier_d = mplier_q >> 1;
    assign count_d  = count_q + CNTW'(1);
    // Stop once no multiplier bits remain, so the final RUN cycle is the
    // one that consumed the top set bit; the count bound caps full-width runs.
    assign run_last = (mplier_d == '0) || (count_q == LAST_CNT);

    // ALU drive is a pure decode of registered state; an opcode is always defined.
    always_comb begin
        alu_op = OP_ZERO;
        alu_a  = '0;
        alu_b  = '0;
        if (state_q == S_RUN) begin
            alu_op = OP_ADD;
            alu_a  = acc_q;
            alu_b  = mplier_q[0] ? mcand_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        if (op_b == '0) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            product_q <= '0;
                            zero_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q    <= alu_result;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_d;
                    if (run_last) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        product_q <= alu_result;
                        zero_q    <= alu_z;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Directed bench for alu_seq_mul with a behavioural combinational ALU.
// Inputs are driven and outputs sampled on the falling edge.
// Cycle n after a start is counted from the edge that accepted it.
module tb_alu_seq_mul;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  product;
    logic          zero;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_z;

    int tests_run = 0;
    int tests_failed = 0;
    int bad_ops = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] alub_seen[$];

    alu_seq_mul #(.BITSIZE(W), .CNTW(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .zero       (zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_z      (alu_z)
    );

    always #5 clk = ~clk;

    // Reference ALU: add for 4'h4, zero for everything else.
    always_comb begin
        alu_result = (alu_op == 4'h4) ? (alu_a + alu_b) : '0;
        alu_z      = (alu_result == '0);
    end

    always @(negedge clk) begin
        if (mon_en && alu_op != 4'h4 && alu_op != 4'h6) bad_ops++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start from a falling edge and follow it until done (bounded).
    // inject=1 pulses a second start at n==2; abort_at>0 asserts reset at that n.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject, input int abort_at,
                          output int done_n, output int run_n, output bit busy_ok);
        int n;
        done_n  = -1;
        run_n   = 0;
        busy_ok = 1'b1;
        alub_seen.delete();
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = 64'hDEAD_BEEF_0BAD_F00D;
        op_b  = 64'hFFFF_0000_FFFF_0000;
        n = 1;
        while (n < 200) begin
            if (alu_op == 4'h4) begin
                run_n++;
                alub_seen.push_back(alu_b);
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_n = n;
                break;
            end
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
                op_a  = 64'd9;
                op_b  = 64'd9;
                break;
            end
            if (inject && n == 2) begin
                start = 1'b1;
                op_a  = 64'd7;
                op_b  = 64'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    int  dn;
    int  rn;
    bit  bok;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_zero",    {63'd0, zero}, 64'd1);
        check("rst_aluop",   {60'd0, alu_op}, 64'h6);
        reset = 1'b0;
        @(negedge clk);

        // Zero multiplier: straight to DONE, no adds.
        run_op(64'd3, 64'd0, 1'b0, 0, dn, rn, bok);
        check("zm_done_n",  dn, 1);
        check("zm_product", product, 64'd0);
        check("zm_zero",    {63'd0, zero}, 64'd1);
        check("zm_runs",    rn, 0);
        @(negedge clk);

        // 3*5: three RUN cycles, alu_b = 3,0,12.
        run_op(64'd3, 64'd5, 1'b0, 0, dn, rn, bok);
        check("sm_done_n",  dn, 4);
        check("sm_runs",    rn, 3);
        check("sm_product", product, 64'd15);
        check("sm_zero",    {63'd0, zero}, 64'd0);
        check("sm_busy",    {63'd0, bok}, 64'd1);
        if (alub_seen.size() == 3) begin
            check("sm_alub0", alub_seen[0], 64'd3);
            check("sm_alub1", alub_seen[1], 64'd0);
            check("sm_alub2", alub_seen[2], 64'd12);
        end else begin
            check("sm_alub_len", alub_seen.size(), 3);
        end
        @(negedge clk);
        check("sm_held", product, 64'd15);

        // Wrap-around: 2^63 * 2 == 0 mod 2^64.
        run_op(64'h8000_0000_0000_0000, 64'd2, 1'b0, 0, dn, rn, bok);
        check("wr_done_n",  dn, 3);
        check("wr_product", product, 64'd0);
        check("wr_zero",    {63'd0, zero}, 64'd1);
        @(negedge clk);

        // Full length: 1 * all-ones.
        run_op(64'd1, {W{1'b1}}, 1'b0, 0, dn, rn, bok);
        check("fl_done_n",  dn, 65);
        check("fl_runs",    rn, 64);
        check("fl_product", product, {W{1'b1}});
        check("fl_zero",    {63'd0, zero}, 64'd0);
        check("fl_busy",    {63'd0, bok}, 64'd1);
        @(negedge clk);

        // Start while busy is dropped.
        run_op(64'd3, 64'd5, 1'b1, 0, dn, rn, bok);
        check("sb_done_n",  dn, 4);
        check("sb_product", product, 64'd15);
        check("sb_runs",    rn, 3);
        @(negedge clk);
        check("sb_idle",    {63'd0, busy}, 64'd0);

        // Reset mid-run at n==2, with a start in the same cycle.
        run_op(64'd3, 64'd5, 1'b0, 2, dn, rn, bok);
        check("rm_no_done", dn, -1);
        @(negedge clk);
        reset = 1'b0;
        check("rm_busy",    {63'd0, busy}, 64'd0);
        check("rm_done",    {63'd0, done}, 64'd0);
        check("rm_product", product, 64'd0);
        check("rm_zero",    {63'd0, zero}, 64'd1);
        check("rm_aluop",   {60'd0, alu_op}, 64'h6);
        @(negedge clk);
        check("rm_stay_idle", {63'd0, busy}, 64'd0);

        check("aluop_legal", bad_ops, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
